// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the master, the DefaultSlave and the DES slaves.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Master FSM: normal pipelined operation, and second cycle of an ERROR response.
  typedef enum logic {
    RUN  = 1'b0,
    ERR2 = 1'b1
  } mst_state_t;

  // Clamp a requested HSIZE to the widest transfer the data bus supports.
  function automatic logic [2:0] cap_hsize(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/ahb_master.sv
// Single-master AHB-Lite initiator: valid/ready commands in, pipelined SINGLE
// transfers out, one in-order response per command. Handles wait states and the
// two-cycle ERROR response by cancelling and replaying the pipelined follower.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  mst_state_t        state_q;
  htrans_t           htrans_q;
  logic              ap_valid_q;
  logic              replay_q;
  logic              dp_valid_q;
  logic              dp_write_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [DATA_W-1:0] ap_wdata_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_error_q;

  // A command may enter the address phase only when the bus advances cleanly and no replay is owed.
  assign cmd_ready = HRESET & HREADY & (HRESP == HRESP_OKAY) & (state_q == RUN) & ~replay_q;

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  // Pipeline FSM: advances address->data->response on HREADY, handles the ERROR/replay sequence.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q     <= RUN;
      htrans_q    <= HTRANS_IDLE;
      ap_valid_q  <= 1'b0;
      replay_q    <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      ap_wdata_q  <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (HREADY) begin
            if (dp_valid_q) begin
              rsp_valid_q <= 1'b1;
              rsp_error_q <= HRESP;
              rsp_rdata_q <= dp_write_q ? '0 : HRDATA;
            end
            dp_valid_q <= ap_valid_q;
            dp_write_q <= hwrite_q;
            hwdata_q   <= (ap_valid_q && hwrite_q) ? ap_wdata_q : '0;
            if (replay_q) begin
              // Address registers were retained when the transfer was cancelled.
              htrans_q   <= HTRANS_NONSEQ;
              ap_valid_q <= 1'b1;
              replay_q   <= 1'b0;
            end else if (cmd_valid && cmd_ready) begin
              htrans_q   <= HTRANS_NONSEQ;
              ap_valid_q <= 1'b1;
              haddr_q    <= cmd_addr;
              hwrite_q   <= cmd_write;
              hsize_q    <= cap_hsize(cmd_size, MAX_SIZE);
              ap_wdata_q <= cmd_wdata;
            end else begin
              htrans_q   <= HTRANS_IDLE;
              ap_valid_q <= 1'b0;
            end
          end else if (dp_valid_q && (HRESP == HRESP_ERROR)) begin
            // First ERROR cycle: withdraw the pending address phase so it can be re-issued later.
            if (ap_valid_q) begin
              replay_q   <= 1'b1;
              htrans_q   <= HTRANS_IDLE;
              ap_valid_q <= 1'b0;
            end
            state_q <= ERR2;
          end
        end
        ERR2: begin
          if (HREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= dp_write_q ? '0 : HRDATA;
            dp_valid_q  <= 1'b0;
            hwdata_q    <= '0;
            state_q     <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: bench-side slave with scripted or random wait/error
// behaviour, a transaction-level model of issue order and responses, and a
// per-cycle compare of the bus and response outputs.
module tb_ahb_master;
  import ahb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [DW-1:0] HWDATA, HRDATA;

  ahb_master #(.ADDR_W(AW), .DATA_W(DW), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    int unsigned   waits;
    logic          err;
    logic [DW-1:0] rdata;
  } slv_t;

  typedef struct packed {
    int            cyc;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  cmd_t send_q[$];    // commands still to be offered
  cmd_t issue_q[$];   // accepted, not yet taken into a data phase
  slv_t script_q[$];  // slave behaviour for upcoming data phases
  rsp_t rsp_log[$];
  int   acc_log[$];

  logic          sl_active;
  cmd_t          sl_cmd;
  slv_t          sl_rsp;
  int unsigned   sl_cnt;
  logic          rsp_due;
  logic [DW-1:0] rsp_exp_data;
  logic          rsp_exp_err;
  logic [2:0]    last_hsize;
  int            cap_108;
  int            cyc;
  int            n_vec, n_err;
  int unsigned   gap_pct;
  logic          rnd_slave;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_cmd();
    if (send_q.size() > 0 && (cmd_valid || $urandom_range(99) >= gap_pct)) begin
      cmd_valid = 1'b1;
      cmd_write = send_q[0].write;
      cmd_addr  = send_q[0].addr;
      cmd_size  = send_q[0].size;
      cmd_wdata = send_q[0].wdata;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_size  = 3'($urandom);
      cmd_wdata = {$urandom, $urandom};
    end
  endtask

  task automatic drive_slave();
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = {$urandom, $urandom};
    if (sl_active) begin
      if (sl_cnt < sl_rsp.waits) begin
        HREADY = 1'b0;
      end else if (sl_rsp.err) begin
        HRESP  = 1'b1;
        HREADY = (sl_cnt > sl_rsp.waits);
        if (HREADY && !sl_cmd.write) HRDATA = sl_rsp.rdata;
      end else if (!sl_cmd.write) begin
        HRDATA = sl_rsp.rdata;
      end
    end else if (rnd_slave) begin
      // Idle bus noise: stalls from the mux and a stray ERROR with nothing in flight.
      HREADY = ($urandom_range(99) >= 10);
      HRESP  = ($urandom_range(99) < 5);
    end
  endtask

  task automatic cycle();
    logic acc, cap, cmpl, exp_ready;
    acc = 1'b0; cap = 1'b0; cmpl = 1'b0;
    @(negedge HCLK);
    if (HRESET) begin
      check("hburst", HBURST, 64'(HBURST_SINGLE));
      check("hprot", HPROT, 64'h3);
      check("hmastlock", HMASTLOCK, 64'h0);
      check("htrans_legal", (HTRANS == 2'b00 || HTRANS == 2'b10), 64'h1);
      check("rsp_valid", rsp_valid, rsp_due);
      if (rsp_due && rsp_valid) begin
        rsp_t r;
        check("rsp_rdata", rsp_rdata, rsp_exp_data);
        check("rsp_error", rsp_error, rsp_exp_err);
        r.cyc = cyc; r.rdata = rsp_rdata; r.err = rsp_error;
        rsp_log.push_back(r);
      end
      // At most one address phase outstanding; once one is owed it must be on the bus before new ones.
      exp_ready = HREADY && !HRESP && (issue_q.size() == 0 || HTRANS == 2'b10);
      check("cmd_ready", cmd_ready, exp_ready);
      if (HTRANS == 2'b10) begin
        if (issue_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL nonseq_unexpected: got NONSEQ at %h expected no transfer (cycle %0d)", HADDR, cyc);
        end else begin
          check("haddr", HADDR, issue_q[0].addr);
          check("hwrite", HWRITE, issue_q[0].write);
          check("hsize", HSIZE, (issue_q[0].size > 3) ? 64'h3 : 64'(issue_q[0].size));
          cap = HREADY;
        end
      end
      if (sl_active && sl_rsp.err && sl_cnt > sl_rsp.waits)
        check("htrans_err2", HTRANS, 64'h0);
      if (sl_active)
        check("hwdata", HWDATA, sl_cmd.write ? sl_cmd.wdata : 64'h0);
      acc  = cmd_valid && cmd_ready;
      cmpl = sl_active && HREADY;
      if (acc) acc_log.push_back(cyc);
      if (cap) begin
        last_hsize = HSIZE;
        if (HADDR == 32'h108) cap_108++;
      end
    end
    @(posedge HCLK);
    cyc++;
    #1;
    if (HRESET) begin
      rsp_due = cmpl;
      if (cmpl) begin
        rsp_exp_data = sl_cmd.write ? '0 : sl_rsp.rdata;
        rsp_exp_err  = sl_rsp.err;
        sl_active    = 1'b0;
      end else if (sl_active) begin
        sl_cnt++;
      end
      if (cap) begin
        sl_cmd    = issue_q.pop_front();
        sl_active = 1'b1;
        sl_cnt    = 0;
        if (script_q.size() > 0) begin
          sl_rsp = script_q.pop_front();
        end else begin
          sl_rsp.waits = ($urandom_range(1) == 0) ? 0 : $urandom_range(3);
          sl_rsp.err   = ($urandom_range(99) < 12);
          sl_rsp.rdata = {$urandom, $urandom};
        end
      end
      if (acc) issue_q.push_back(send_q.pop_front());
    end
    drive_cmd();
    drive_slave();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((send_q.size() > 0 || issue_q.size() > 0 || sl_active || rsp_due) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending after %0d cycles expected 0", send_q.size() + issue_q.size(), n);
    end
    repeat (2) cycle();
  endtask

  function automatic cmd_t mk(input logic w, input logic [AW-1:0] a, input logic [2:0] s, input logic [DW-1:0] d);
    cmd_t c;
    c.write = w; c.addr = a; c.size = s; c.wdata = d;
    return c;
  endfunction

  function automatic slv_t sl(input int unsigned w, input logic e, input logic [DW-1:0] d);
    slv_t s;
    s.waits = w; s.err = e; s.rdata = d;
    return s;
  endfunction

  task automatic clear_logs();
    rsp_log.delete();
    acc_log.delete();
    cap_108 = 0;
  endtask

  initial begin
    logic [63:0] b2b_data [4];
    b2b_data[0] = 64'hA0A0_0000_0000_0000;
    b2b_data[1] = 64'hA1A1_1111_1111_1111;
    b2b_data[2] = 64'hA2A2_2222_2222_2222;
    b2b_data[3] = 64'hA3A3_3333_3333_3333;
    n_vec = 0; n_err = 0; cyc = 0; gap_pct = 0; rnd_slave = 1'b0;
    sl_active = 1'b0; rsp_due = 1'b0; sl_cnt = 0; last_hsize = '0; cap_108 = 0;
    rsp_exp_data = '0; rsp_exp_err = 1'b0;
    HRESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;

    // Reset state
    #2;
    check("rst_htrans", HTRANS, 64'h0);
    check("rst_haddr", HADDR, 64'h0);
    check("rst_hwrite", HWRITE, 64'h0);
    check("rst_hsize", HSIZE, 64'h0);
    check("rst_hwdata", HWDATA, 64'h0);
    check("rst_rsp_valid", rsp_valid, 64'h0);
    check("rst_rsp_rdata", rsp_rdata, 64'h0);
    check("rst_rsp_error", rsp_error, 64'h0);
    check("rst_cmd_ready", cmd_ready, 64'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    drive_cmd(); drive_slave();
    repeat (2) cycle();

    // Single zero-wait write
    clear_logs();
    send_q.push_back(mk(1'b1, 32'h0000_0010, 3'd3, 64'hDEAD_BEEF_0123_4567));
    script_q.push_back(sl(0, 1'b0, '0));
    wait_idle(50);
    check("wr_rsp_count", rsp_log.size(), 64'd1);
    if (rsp_log.size() == 1 && acc_log.size() == 1) begin
      check("wr_rsp_error", rsp_log[0].err, 64'h0);
      check("wr_rsp_rdata", rsp_log[0].rdata, 64'h0);
      check("wr_latency", 64'(rsp_log[0].cyc - acc_log[0]), 64'd3);
    end

    // Read with two wait states
    clear_logs();
    send_q.push_back(mk(1'b0, 32'h0000_0020, 3'd3, '0));
    script_q.push_back(sl(2, 1'b0, 64'h1122_3344_5566_7788));
    wait_idle(50);
    check("rd_rsp_count", rsp_log.size(), 64'd1);
    if (rsp_log.size() == 1 && acc_log.size() == 1) begin
      check("rd_rsp_rdata", rsp_log[0].rdata, 64'h1122_3344_5566_7788);
      check("rd_latency", 64'(rsp_log[0].cyc - acc_log[0]), 64'd5);
    end

    // Four back-to-back reads
    clear_logs();
    for (int unsigned i = 0; i < 4; i++) begin
      send_q.push_back(mk(1'b0, 32'(i * 8), 3'd3, '0));
      script_q.push_back(sl(0, 1'b0, b2b_data[i]));
    end
    wait_idle(50);
    check("b2b_rsp_count", rsp_log.size(), 64'd4);
    if (rsp_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_rdata", rsp_log[i].rdata, b2b_data[i]);
        check("b2b_spacing", 64'(rsp_log[i].cyc - rsp_log[0].cyc), 64'(i));
      end
    end

    // ERROR on a write with a pipelined read behind it
    clear_logs();
    send_q.push_back(mk(1'b1, 32'h0000_0100, 3'd3, 64'h0BAD_F00D_0BAD_F00D));
    send_q.push_back(mk(1'b0, 32'h0000_0108, 3'd3, '0));
    script_q.push_back(sl(0, 1'b1, '0));
    script_q.push_back(sl(0, 1'b0, 64'hCAFE_BABE_1234_5678));
    wait_idle(50);
    check("err_rsp_count", rsp_log.size(), 64'd2);
    if (rsp_log.size() == 2) begin
      check("err_wr_error", rsp_log[0].err, 64'h1);
      check("err_wr_rdata", rsp_log[0].rdata, 64'h0);
      check("err_rd_error", rsp_log[1].err, 64'h0);
      check("err_rd_rdata", rsp_log[1].rdata, 64'hCAFE_BABE_1234_5678);
      check("err_replay_gap", 64'(rsp_log[1].cyc - rsp_log[0].cyc), 64'd3);
    end
    check("err_replay_issues", 64'(cap_108), 64'd1);

    // Oversize HSIZE request
    clear_logs();
    send_q.push_back(mk(1'b0, 32'h0000_0040, 3'b101, '0));
    script_q.push_back(sl(0, 1'b0, 64'h5555_AAAA_5555_AAAA));
    wait_idle(50);
    check("oversize_hsize", last_hsize, 64'h3);

    // Asynchronous reset in the middle of a transfer
    clear_logs();
    send_q.push_back(mk(1'b1, 32'h0000_0200, 3'd2, 64'h7777_8888_9999_AAAA));
    script_q.push_back(sl(6, 1'b0, '0));
    repeat (4) cycle();
    #2;
    HRESET = 1'b0;
    #1;
    check("arst_htrans", HTRANS, 64'h0);
    check("arst_rsp_valid", rsp_valid, 64'h0);
    check("arst_hwdata", HWDATA, 64'h0);
    check("arst_cmd_ready", cmd_ready, 64'h0);
    send_q.delete(); issue_q.delete(); script_q.delete();
    sl_active = 1'b0; rsp_due = 1'b0;
    cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) cycle();
    HRESET = 1'b1;
    repeat (8) cycle();
    check("arst_no_rsp", rsp_log.size(), 64'd0);

    // Randomized traffic
    clear_logs();
    gap_pct = 30;
    rnd_slave = 1'b1;
    for (int unsigned i = 0; i < 300; i++) begin
      send_q.push_back(mk(1'($urandom), {$urandom_range(4095), 3'b000}, 3'($urandom), {$urandom, $urandom}));
    end
    wait_idle(20000);
    check("rnd_rsp_count", rsp_log.size(), 64'd300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_master.md
Name: ahb_master

Overview:
- Single-master AHB-Lite initiator; the requesting end of the bus the DefaultSlave and the Triple DES slaves respond to.
- Converts a simple valid/ready command stream into pipelined AHB-Lite SINGLE transfers on a 64-bit data bus.
- Returns one response (read data and error flag) per command, in issue order.
- Handles slave wait states and the two-cycle ERROR response, including cancelling and replaying the following transfer.

Parameters:
ADDR_W, 32, HADDR width
DATA_W, 64, HWDATA/HRDATA width; HSIZE is capped at log2(DATA_W/8)=3
HPROT_VAL, 4'b0011, constant HPROT (non-cacheable, privileged, data)

Ports:
HCLK  in  1  bus clock, rising edge
HRESET  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted at this edge when cmd_valid is also high
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_size  in  3  HSIZE encoding; values >3 forced to 3
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_error  out  1  slave returned ERROR
HADDR  out  ADDR_W  address phase
HTRANS  out  2  IDLE=00 or NONSEQ=10 only
HWRITE  out  1  address phase
HSIZE  out  3  address phase
HBURST  out  3  constant SINGLE=000
HPROT  out  4  constant HPROT_VAL
HMASTLOCK  out  1  constant 0
HWDATA  out  DATA_W  data phase write data
HREADY  in  1  bus ready (from the slave mux)
HRESP  in  1  0 = OKAY, 1 = ERROR
HRDATA  in  DATA_W  read data

Behaviour:
- Reset (HRESET=0, asynchronous):
  - HTRANS=IDLE; HADDR, HWRITE, HSIZE, HWDATA = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0; cmd_ready is low while reset is asserted.
  - Internal state: ap_valid=0, dp_valid=0, replay=0, state=RUN.
  - Any in-flight transfer is dropped and produces no response.
- All address-phase outputs are registered and held stable while HREADY=0.
- FSM states: RUN, ERR2.
- RUN, edge with HREADY=1:
  - Address phase to data phase: dp_valid<=ap_valid, dp_write<=HWRITE. For writes, HWDATA<=held wdata; otherwise HWDATA<=0.
  - If the replay flag is set, the held command is re-driven: HTRANS<=NONSEQ, replay<=0.
  - Otherwise, if cmd_valid, load a new address phase: HTRANS<=NONSEQ and capture addr, size, write, wdata.
  - Otherwise HTRANS<=IDLE.
- cmd_ready = HREADY & ~HRESP & (state==RUN) & ~replay. This is a combinational path from HREADY/HRESP, which is permitted.
- Data-phase completion (dp_valid at an edge with HREADY=1):
  - Next cycle: rsp_valid=1, rsp_error=HRESP.
  - rsp_rdata = HRDATA for reads, 0 for writes.
  - Back-to-back zero-wait transfers give one response per cycle.
- Latency, zero wait states:
  - cmd accepted at edge 0; NONSEQ visible in cycle 0→1.
  - Data phase in cycle 1→2; rsp_valid in cycle 2→3.
  - Each HREADY=0 cycle adds one cycle.
- ERROR, first cycle (dp_valid, HRESP=1, HREADY=0):
  - If ap_valid, set replay<=1 and HTRANS<=IDLE, retaining the address/data registers. This cancels the pending transfer.
  - Enter ERR2.
- ERR2 (HRESP=1, HREADY=1 expected):
  - The errored transfer completes and is reported with rsp_error=1.
  - HTRANS stays IDLE; return to RUN.
  - The replayed command issues NONSEQ on the following RUN edge. The cancelled command never produces a response of its own before its replay.
- HRESP=1 with no data phase active (protocol violation): ignored, no response generated.
- IDLE transfers never create a data phase or a response.
- HSIZE: cmd_size>3 is driven as 3'b011. Address alignment is not checked.

Decomposition:
- Shared package ahb_pkg:
  - htrans_t (IDLE, BUSY, NONSEQ, SEQ).
  - hburst constants (SINGLE…).
  - hsize constants (BYTE, HALF, WORD, DWORD).
  - HRESP_OKAY/HRESP_ERROR.
  - FSM state enum {RUN, ERR2}.
- Package is shared with DefaultSlave and the DES slaves.
- Flat module; no sub-module is natural.

Test Plan:
- Reset:
  - Stimulus: assert HRESET=0 mid-transfer.
  - Required: HTRANS=00, rsp_valid=0, HWDATA=0 immediately (asynchronous); no response after release.
- Single write, zero wait:
  - Stimulus: cmd write addr=32'h0000_0010, size=3, wdata=64'hDEAD_BEEF_0123_4567.
  - Required: HTRANS=10, HADDR=0x10, HWRITE=1 for 1 cycle; HWDATA=wdata the next cycle; rsp_valid, rsp_error=0 the cycle after.
- Read with 2 wait states:
  - Stimulus: cmd read addr=0x20; slave holds HREADY=0 for 2 cycles, then returns HRDATA=64'h1122_3344_5566_7788.
  - Required: address outputs stable during waits; rsp_rdata=0x1122334455667788.
- Back-to-back:
  - Stimulus: 4 reads to 0x0, 0x8, 0x10, 0x18 with cmd_valid held high, zero-wait slave.
  - Required: 4 consecutive NONSEQ cycles; 4 consecutive rsp_valid pulses, in order.
- ERROR with pipelined follower:
  - Stimulus: write 0x100 then read 0x108; DefaultSlave-style 2-cycle ERROR on the write.
  - Required: HTRANS=IDLE in the second error cycle; rsp_error=1 for the write; read re-issued as NONSEQ at 0x108 and completes with rsp_error=0.
- Oversize:
  - Stimulus: cmd_size=3'b101.
  - Required: HSIZE=3'b011 on the bus.
